// File: rtl/multiword_adder_ctrl_if.sv
// Request/result bundle between a requesting unit and multiword_adder_ctrl.
interface multiword_adder_ctrl_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = 32 * WORDS;

  logic         start;
  logic [W:1]   a_in;
  logic [W:1]   b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W:1]   sum_out;
  logic         cout_out;
  logic         ovf;

  // Requesting unit side
  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum_out, cout_out, ovf
  );

  // Sequencer side
  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum_out, cout_out, ovf
  );
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Wide adder sequencer: one 32-bit add per cycle, least-significant word
// first, carry chained through a register; result flagged by a done pulse.
// Optional feature: define ADDER_OVF_EN to compute signed overflow on ovf;
// otherwise ovf is tied to 0.
module multiword_adder_ctrl #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  multiword_adder_ctrl_if.slave bus
);
  localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [WORDS-1:0][31:0]  a_q, a_d;
  logic [WORDS-1:0][31:0]  b_q, b_d;
  logic [WORDS-1:0][31:0]  sum_q, sum_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
`ifdef ADDER_OVF_EN
  logic                    ovf_q, ovf_d;
`endif

  // Shared 32-bit word adder, time-multiplexed across words
  logic [31:0] add_sum_c;
  logic        add_cout_c;

  always_comb begin
    {add_cout_c, add_sum_c} = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {32'd0, carry_q};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
`ifdef ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        sum_d[idx_q] = add_sum_c;
        carry_d      = add_cout_c;
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = add_cout_c;
          done_d  = 1'b1;
          state_d = ST_DONE;
`ifdef ADDER_OVF_EN
          ovf_d   = (a_q[WORDS-1][31] == b_q[WORDS-1][31]) &&
                    (add_sum_c[31] != a_q[WORDS-1][31]);
`endif
        end else begin
          idx_d  = idx_q + IDXW'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum_out  = sum_q;
  assign bus.cout_out = cout_q;
`ifdef ADDER_OVF_EN
  assign bus.ovf      = ovf_q;
`else
  assign bus.ovf      = 1'b0;
`endif

endmodule
